// File: rtl/srl_seq.sv
// Sequential right shifter: one bit position per clock, logical or arithmetic fill.
// Latency: shamt+2 cycles from the start edge to the done pulse.
// Backpressure: start is ignored while busy; a start during the done cycle is accepted back-to-back.
module srl_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] num,
    input  logic [SHW-1:0]   shamt,
    input  logic             arith,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] opr;
    logic [SHW-1:0]   cnt;
    logic             fill;
    logic             load;
    logic             cnt_zero;

    assign cnt_zero = (cnt == '0);
    // Only an idle or just-finished shifter may take a new request.
    assign load     = start && (state != SHIFT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt_zero) state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            opr    <= '0;
            cnt    <= '0;
            fill   <= 1'b0;
            result <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                opr  <= num;
                cnt  <= shamt;
                fill <= arith & num[WIDTH-1];
            end else if (state == SHIFT && !cnt_zero) begin
                opr <= {fill, opr[WIDTH-1:1]};
                cnt <= cnt - CNT_ONE;
            end
            if (state == SHIFT && cnt_zero) begin
                result <= opr;
            end
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_srl_seq.sv
// Bench for srl_seq: directed vector table, hand-written corner sequences, and random back-to-back ops vs. a shift-operator model.
module tb_srl_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] num;
    logic [4:0]  shamt;
    logic        arith;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int passed = 0;
    int total  = 0;

    srl_seq #(.WIDTH(32), .SHW(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .num    (num),
        .shamt  (shamt),
        .arith  (arith),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] n;
        logic [4:0]  s;
        logic        a;
        logic [31:0] exp_res;
        int          exp_lat;
        int          exp_busy;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    endtask

    function automatic logic [31:0] model(input logic [31:0] n, input int s, input bit a);
        logic signed [31:0] sn;
        sn = n;
        return a ? 32'($unsigned(sn >>> s)) : (n >> s);
    endfunction

    // Caller is at a negedge; returns at the negedge of the done cycle (or after the bound).
    task automatic run_op(input logic [31:0] n, input logic [4:0] s, input bit a,
                          output logic [31:0] res, output int lat, output int bcnt);
        start = 1'b1; num = n; shamt = s; arith = a;
        @(negedge clk);
        start = 1'b0;
        lat = 1; bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        res = result;
        if (!done) lat = -1;
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] exp_res;
        logic [31:0] prev_res;
        int          lat, bcnt, cyc, exp_lat;
        bit          hold_ok, saw_done;

        vecs[0] = '{32'hF000_0000, 5'd4,  1'b0, 32'h0F00_0000, 6,  5};
        vecs[1] = '{32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 33, 32};
        vecs[2] = '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 33, 32};
        vecs[3] = '{32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678, 2,  1};
        vecs[4] = '{32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678, 2,  1};
        vecs[5] = '{32'h8765_4321, 5'd8,  1'b1, 32'hFF87_6543, 10, 9};
        vecs[6] = '{32'h8765_4321, 5'd8,  1'b0, 32'h0087_6543, 10, 9};
        vecs[7] = '{32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000, 33, 32};
        vecs[8] = '{32'hA5A5_A5A5, 5'd31, 1'b1, 32'hFFFF_FFFF, 33, 32};

        rst_n = 1'b0; start = 1'b0; num = '0; shamt = '0; arith = 1'b0;
        #1;
        chk("reset_result", result, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);

        // Reset releases at a negedge and the first start is driven at once.
        @(negedge clk);
        rst_n = 1'b1;
        foreach (vecs[i]) begin
            run_op(vecs[i].n, vecs[i].s, vecs[i].a, res, lat, bcnt);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].exp_busy);
            @(negedge clk);
        end

        // Start while busy is ignored; start in the done cycle is accepted.
        start = 1'b1; num = 32'h1111_0000; shamt = 5'd3; arith = 1'b0;
        @(negedge clk);
        start = 1'b1; num = 32'hFFFF_FFFF; shamt = 5'd1; arith = 1'b1;
        cyc = 1;
        @(negedge clk);
        start = 1'b0; num = 32'hDEAD_BEEF;
        cyc = 2;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("busy_start_latency", cyc, 5);
        chk("busy_start_result", result, 32'h0222_2000);
        run_op(32'hC000_0000, 5'd2, 1'b1, res, lat, bcnt);
        chk("b2b_result", res, 32'hF000_0000);
        chk("b2b_latency", lat, 4);
        @(negedge clk);

        // Asynchronous reset in the middle of a long shift.
        start = 1'b1; num = 32'hABCD_0123; shamt = 5'd20; arith = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_result", result, 32'h0);
        chk("midreset_busy", {31'b0, busy}, 32'h0);
        chk("midreset_done", {31'b0, done}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        chk("midreset_no_done", {31'b0, saw_done}, 32'h0);

        // Random ops with noise on the inputs while busy, mixed idle gaps and back-to-back starts.
        start = 1'b1; num = $urandom; shamt = 5'($urandom_range(0, 31)); arith = 1'($urandom);
        for (int op = 0; op < 1000; op++) begin
            exp_res  = model(num, int'(shamt), arith);
            exp_lat  = int'(shamt) + 2;
            prev_res = result;
            hold_ok  = 1'b1;
            @(negedge clk);
            cyc = 1;
            while (!done && cyc < 100) begin
                if (result !== prev_res) hold_ok = 1'b0;
                start = 1'($urandom); num = $urandom;
                shamt = 5'($urandom); arith = 1'($urandom);
                @(negedge clk);
                cyc++;
            end
            chk($sformatf("rnd%0d_result", op), result, exp_res);
            chk($sformatf("rnd%0d_latency", op), cyc, exp_lat);
            chk($sformatf("rnd%0d_hold", op), {31'b0, hold_ok}, 32'h1);
            if ($urandom_range(0, 1) == 0) begin
                start = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            start = 1'b1; num = $urandom; shamt = 5'($urandom_range(0, 31)); arith = 1'($urandom);
        end
        start = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/srl_seq.md
SRL_SEQ -- requirements
Module: srl_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits.
REQ-002 SHALL have parameter SHW, default 5, shift-amount width; WIDTH SHALL equal 2**SHW.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request; sampled only when busy=0.
REQ-006 num  input  WIDTH  operand, captured with start.
REQ-007 shamt  input  SHW  right-shift amount, captured with start.
REQ-008 arith  input  1  0 = logical (zero fill), 1 = arithmetic (sign fill); captured with start.
REQ-009 result  output  WIDTH  shifted value; valid from done pulse until next accepted start.
REQ-010 busy  output  1  high while operation in progress.
REQ-011 done  output  1  one-cycle completion pulse.

Function
REQ-012 SHALL implement FSM with states IDLE, SHIFT, DONE.
REQ-013 start=1 with busy=0 (IDLE or DONE) SHALL load an operand register from num, a counter from shamt and a fill bit (arith & num[WIDTH-1]), then enter SHIFT.
REQ-014 In SHIFT with counter>0, each edge SHALL shift the operand register right by one bit, insert the fill bit at MSB and decrement the counter.
REQ-015 In SHIFT with counter=0, the next edge SHALL enter DONE and copy the operand register to result.
REQ-016 done SHALL be 1 exactly while in DONE; busy SHALL be 1 exactly while in SHIFT.
REQ-017 From DONE without start, the next edge SHALL return to IDLE; with start, SHALL load new operands and enter SHIFT (back-to-back).
REQ-018 Latency: start sampled at edge k SHALL give done=1 in the cycle after edge k+shamt+1; total shamt+2 cycles.
REQ-019 shamt=0 SHALL give result=num with done after edge k+1.
REQ-020 shamt=WIDTH-1 SHALL give all-fill except bit0=num[WIDTH-1].
REQ-021 start while busy=1 SHALL be ignored; operands and counter SHALL be unaffected.
REQ-022 Changes to num, shamt, arith after capture SHALL NOT affect the operation in progress.
REQ-023 result SHALL hold its value from the DONE entry until the next DONE entry; it SHALL NOT change during SHIFT.

Reset
REQ-024 rst_n=0 SHALL immediately, without clock, force state IDLE, result=0, busy=0, done=0, counter=0, operand register=0.
REQ-025 Reset asserted mid-SHIFT SHALL abort the operation; no done pulse SHALL follow after release.
REQ-026 First start SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-027 num=0xF0000000, shamt=4, arith=0 -> result=0x0F000000, done after 6 cycles, busy high 5 cycles.
REQ-028 num=0x80000000, shamt=31, arith=1 -> result=0xFFFFFFFF; same operand arith=0 -> result=0x00000001.
REQ-029 num=0x12345678, shamt=0 -> result=0x12345678, done 2 cycles after start, busy high 1 cycle.
REQ-030 start with shamt=3, second start (num=0xFFFFFFFF) while busy -> ignored; first result unaffected; start during DONE pulse accepted, next result correct.
REQ-031 rst_n pulsed low mid-SHIFT (shamt=20, cycle 5) -> outputs 0 asynchronously, no done afterwards until new start.
REQ-032 Random num/shamt/arith, 1000 ops vs. reference model (>> / >>>), back-to-back starts -> all results and latencies match.
